// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source interrupt controller feeding the single core interrupt request.
//
// Rising edges on irq_src latch into the pending register. Pending sources that are also enabled
// in the mask are arbitrated, with index 0 taking the highest priority. The winner is requested
// from the core through a REQ / WAIT_DIS / SERVICE handshake on irq_en and irq_ack.
//
// Ports:
//   clk       core clock
//   rst       synchronous active-low reset
//   irq_src   peripheral interrupt lines (rising-edge triggered)
//   sr_ie     special-register write enable
//   sr_sel    special-register select
//   sr_in     special-register write data
//   sr_out    special-register read data, zero outside the three owned addresses
//   irq_en    global interrupt enable (IRQEN)
//   irq_ack   one-cycle pulse when the PC takes the interrupt jump
//   irq_out   interrupt request to the core
//   irq_busy  request in flight or handler running
module irq_ctrl #(
  parameter int unsigned N_SRC   = 8,
  parameter logic [15:0] SR_BASE = 16'h0005
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             sr_ie,
  input  logic [15:0]      sr_sel,
  input  logic [15:0]      sr_in,
  output logic [15:0]      sr_out,
  input  logic             irq_en,
  input  logic             irq_ack,
  output logic             irq_out,
  output logic             irq_busy
);

  localparam logic [15:0] SrMask  = SR_BASE;
  localparam logic [15:0] SrPend  = SR_BASE + 16'd1;
  localparam logic [15:0] SrCause = SR_BASE + 16'd2;

  typedef enum logic [1:0] {StIdle, StReq, StWaitDis, StService} state_e;

  state_e           state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] src_q;
  logic             valid_q, valid_d;
  logic [3:0]       id_q, id_d;

  logic [N_SRC-1:0] set_vec, w1c_vec, ack_clr, eligible;
  logic [3:0]       win_id;

  // Upper write-data bits are unused when N_SRC < 16.
  logic unused_sr_in;
  assign unused_sr_in = ^sr_in;

  assign set_vec  = irq_src & ~src_q;
  assign eligible = pending_q & mask_q;
  assign w1c_vec  = (sr_ie && sr_sel == SrPend) ? sr_in[N_SRC-1:0] : '0;

  // Lowest set index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_id = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    ack_clr = '0;
    case (state_q)
      StIdle: begin
        if (irq_en && |eligible) begin
          id_d    = win_id;
          valid_d = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (irq_ack) begin
          for (int i = 0; i < int'(N_SRC); i++) ack_clr[i] = (id_q == 4'(i));
          state_d = StWaitDis;
        end else if (!irq_en) begin
          // Software dropped IE before the jump: withdraw, leave pending for a later retry.
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      StWaitDis: if (!irq_en) state_d = StService;
      StService: if (irq_en) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A new edge beats a same-cycle clear so no event is lost.
  assign pending_d = (pending_q & ~(w1c_vec | ack_clr)) | set_vec;
  assign mask_d    = (sr_ie && sr_sel == SrMask) ? sr_in[N_SRC-1:0] : mask_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      pending_q <= '0;
      src_q     <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pending_q <= pending_d;
      src_q     <= irq_src;
      valid_q   <= valid_d;
      id_q      <= id_d;
    end
  end

  always_comb begin
    sr_out = '0;
    if (sr_sel == SrMask) begin
      sr_out[N_SRC-1:0] = mask_q;
    end else if (sr_sel == SrPend) begin
      sr_out[N_SRC-1:0] = pending_q;
    end else if (sr_sel == SrCause) begin
      sr_out = {valid_q, 11'b0, id_q};
    end
  end

  assign irq_out  = (state_q == StReq);
  assign irq_busy = (state_q != StIdle);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (N_SRC=8, SR_BASE=5).
module tb_irq_ctrl;

  localparam logic [15:0] Base = 16'h0005;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        sr_ie;
  logic [15:0] sr_sel;
  logic [15:0] sr_in;
  logic [15:0] sr_out;
  logic        irq_en;
  logic        irq_ack;
  logic        irq_out;
  logic        irq_busy;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N_SRC(8), .SR_BASE(Base)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .sr_ie    (sr_ie),
    .sr_sel   (sr_sel),
    .sr_in    (sr_in),
    .sr_out   (sr_out),
    .irq_en   (irq_en),
    .irq_ack  (irq_ack),
    .irq_out  (irq_out),
    .irq_busy (irq_busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [15:0] sel, output logic [15:0] d);
    sr_sel = sel;
    #1;
    d = sr_out;
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] d);
    sr_ie  = 1'b1;
    sr_sel = sel;
    sr_in  = d;
    tick();
    sr_ie  = 1'b0;
  endtask

  // ack, disable, re-enable: REQ -> WAIT_DIS -> SERVICE -> IDLE
  task automatic service_cycle();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_en  = 1'b0;
    tick();
    irq_en  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b0; irq_src = '0; sr_ie = 1'b0; sr_sel = '0; sr_in = '0;
    irq_en = 1'b0; irq_ack = 1'b0;
    tick(2);
    rst = 1'b1;
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL reset_irq_out got %b want 0", irq_out); end
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", irq_busy); end
    rd(Base, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_mask got %h want 0000", d); end
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_pending got %h want 0000", d); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_cause got %h want 0000", d); end
  endtask

  task automatic test_single();
    logic [15:0] d;
    irq_en = 1'b1;
    wr(Base, 16'h0004);
    irq_src = 8'h04;
    tick();
    irq_src = '0;
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0004) begin n_fail++; $display("FAIL single_pending got %h want 0004", d); end
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL single_early_req got %b want 0", irq_out); end
    tick();
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL single_req got %b want 1", irq_out); end
    n_checks++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", irq_busy); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h8002) begin n_fail++; $display("FAIL single_cause got %h want 8002", d); end
    tick(2);
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL single_req_hold got %b want 1", irq_out); end
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL single_ack_clr got %h want 0000", d); end
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL single_ack_drop got %b want 0", irq_out); end
    irq_en = 1'b0;
    tick(4);
    n_checks++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL single_service_busy got %b want 1", irq_busy); end
    irq_en = 1'b1;
    tick();
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", irq_busy); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h8002) begin n_fail++; $display("FAIL single_cause_kept got %h want 8002", d); end
  endtask

  task automatic test_priority();
    logic [15:0] d;
    wr(Base, 16'h00FF);
    irq_src = 8'h22;
    tick();
    irq_src = '0;
    tick();
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h8001) begin n_fail++; $display("FAIL prio_first got %h want 8001", d); end
    service_cycle();
    // Back in IDLE with src 5 still pending; request follows on the next edge.
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL prio_gap got %b want 0", irq_out); end
    tick();
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL prio_second_req got %b want 1", irq_out); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h8005) begin n_fail++; $display("FAIL prio_second got %h want 8005", d); end
    service_cycle();
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL prio_drained got %h want 0000", d); end
  endtask

  task automatic test_mask_w1c();
    logic [15:0] d;
    wr(Base, 16'h0000);
    irq_src = 8'h08;
    tick();
    irq_src = '0;
    tick();
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0008) begin n_fail++; $display("FAIL masked_pending got %h want 0008", d); end
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL masked_no_req got %b want 0", irq_out); end
    wr(Base + 16'd1, 16'h0008);
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL w1c got %h want 0000", d); end
    wr(Base, 16'h0008);
    tick(2);
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL unmask_no_req got %b want 0", irq_busy); end
    rd(Base, d);
    n_checks++; if (d !== 16'h0008) begin n_fail++; $display("FAIL mask_read got %h want 0008", d); end
    wr(Base + 16'd2, 16'hFFFF);
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h8005) begin n_fail++; $display("FAIL cause_ro got %h want 8005", d); end
  endtask

  task automatic test_collision();
    logic [15:0] d;
    wr(Base, 16'h0000);
    irq_src = 8'h10;
    tick();
    irq_src = '0;
    tick();
    // W1C of bit 4 and a new edge on src 4 in the same cycle.
    irq_src = 8'h10;
    sr_ie = 1'b1; sr_sel = Base + 16'd1; sr_in = 16'h0010;
    tick();
    sr_ie = 1'b0; irq_src = '0;
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0010) begin n_fail++; $display("FAIL w1c_collision got %h want 0010", d); end
    wr(Base + 16'd1, 16'h0010);
    wr(Base, 16'h0010);
    irq_src = 8'h10;
    tick();
    irq_src = '0;
    tick();
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL ack_coll_req got %b want 1", irq_out); end
    // Ack clears the cause bit while a fresh edge arrives on the same source.
    irq_ack = 1'b1; irq_src = 8'h10;
    tick();
    irq_ack = 1'b0; irq_src = '0;
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0010) begin n_fail++; $display("FAIL ack_collision got %h want 0010", d); end
    irq_en = 1'b0;
    tick();
    wr(Base, 16'h0000);
    irq_en = 1'b1;
    tick();
    wr(Base + 16'd1, 16'h0010);
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL coll_idle got %b want 0", irq_busy); end
  endtask

  task automatic test_abort();
    logic [15:0] d;
    wr(Base, 16'h0040);
    irq_src = 8'h40;
    tick();
    irq_src = '0;
    tick();
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL abort_req got %b want 1", irq_out); end
    wr(Base, 16'h0000);
    n_checks++; if (irq_out !== 1'b1) begin n_fail++; $display("FAIL mask_in_req got %b want 1", irq_out); end
    irq_en = 1'b0;
    tick();
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL abort_drop got %b want 0", irq_out); end
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got %b want 0", irq_busy); end
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0040) begin n_fail++; $display("FAIL abort_pending got %h want 0040", d); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h0006) begin n_fail++; $display("FAIL abort_cause got %h want 0006", d); end
    irq_en = 1'b1;
    wr(Base + 16'd1, 16'h0040);
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    wr(Base, 16'h00FF);
    irq_src = 8'h02;
    tick(2);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_en = 1'b0;
    tick();
    n_checks++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_service got %b want 1", irq_busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_checks++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", irq_busy); end
    rd(Base, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_mask got %h want 0000", d); end
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_pending got %h want 0000", d); end
    rd(Base + 16'd2, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_cause got %h want 0000", d); end
    wr(Base, 16'h00A5);
    rd(16'h0003, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL out_of_range got %h want 0000", d); end
    rd(16'h0008, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL above_range got %h want 0000", d); end
    wr(Base, 16'h0000);
    // Source is still held high: once pending is cleared it must not come back.
    wr(Base + 16'd1, 16'h00FF);
    tick(3);
    rd(Base + 16'd1, d);
    n_checks++; if (d !== 16'h0000) begin n_fail++; $display("FAIL level_no_retrigger got %h want 0000", d); end
    wr(Base, 16'h0002);
    irq_en = 1'b1;
    tick(3);
    n_checks++; if (irq_out !== 1'b0) begin n_fail++; $display("FAIL level_no_req got %b want 0", irq_out); end
    irq_src = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_w1c();
    test_collision();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Multi-source interrupt controller that sequences the single interrupt request into the special-register block.
- Edge-detects up to N_SRC peripheral interrupt lines and latches them as pending. Applies a mask, then picks the highest-priority source.
- Drives the core interrupt request through a handshake with the PC/special-register logic.
- Exposes mask, pending and cause registers on the special-register bus at SR_BASE..SR_BASE+2.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16).
- SR_BASE, 16'h0005, sr_sel index of the mask register. Pending is at SR_BASE+1, cause at SR_BASE+2.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-low reset, sampled on rising clk.
- irq_src  in  N_SRC  peripheral interrupt lines, synchronous to clk, rising-edge triggered.
- sr_ie  in  1  special-register write enable.
- sr_sel  in  16  special-register select.
- sr_in  in  16  special-register write data.
- sr_out  out  16  read data. Zero when sr_sel is outside SR_BASE..SR_BASE+2, so it can be OR-merged.
- irq_en  in  1  global interrupt enable from the special-register block (IRQEN bit).
- irq_ack  in  1  one-cycle pulse: the PC module has taken the interrupt jump.
- irq_out  out  1  interrupt request to the special-register block / PC.
- irq_busy  out  1  high in states REQ, WAIT_DIS and SERVICE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - mask=0, pending=0, cause=0, irq_src_d=0.
  - state=IDLE, so irq_out=0 and irq_busy=0.
  - Reset mid-operation aborts any state immediately; irq_out drops on the next cycle.
- Edge detect: irq_src_d <= irq_src each cycle. set_vec = irq_src & ~irq_src_d.
- Pending update, per bit, each cycle:
  - pending <= (pending & ~clr_vec) | set_vec.
  - Set wins over clear when both occur in the same cycle.
  - clr_vec = (W1C write data) | (ack clear of the cause bit).
  - Masked sources still latch pending.
- Register writes (sr_ie==1):
  - sr_sel==SR_BASE: mask <= sr_in[N_SRC-1:0].
  - sr_sel==SR_BASE+1: write-1-to-clear pending.
  - sr_sel==SR_BASE+2: ignored.
- Register reads (combinational):
  - mask and pending are zero-extended to 16 bits.
  - cause = {valid, 11'b0, id[3:0]}.
- Arbitration: eligible = pending & mask. The winner is the lowest set index; index 0 has the highest priority.
- FSM:
  - IDLE: irq_out=0. If irq_en && |eligible, latch cause.id=winner and cause.valid=1, then go to REQ.
  - REQ: irq_out=1.
    - If irq_ack: clear pending[cause.id] and go to WAIT_DIS.
    - Else if !irq_en (software disabled IE before the jump): go to IDLE, pending unchanged, cause.valid<=0.
    - Mask changes in REQ do not cancel the request.
  - WAIT_DIS: irq_out=0. When irq_en==0 (the special-register block clears IRQEN after irq_in falls), go to SERVICE.
  - SERVICE: irq_out=0, handler running. When irq_en==1 (return from interrupt re-enables IE), go to IDLE. cause is kept.
- Latency: a source edge at cycle t with mask set, irq_en=1 and state IDLE gives pending=1 at t+1, REQ at t+2 and irq_out=1 at t+2 (irq_out is registered from state).
- No new request can be raised in REQ, WAIT_DIS or SERVICE. Edges arriving in those states accumulate in pending.
- cause.valid is cleared only on reset or on the REQ abort path.
- Software can write cause.id/valid only indirectly, through the FSM.

Test Plan:
- Single source: mask=8'h04, irq_en=1, pulse irq_src[2] at cycle 10 -> pending=8'h04 at 11, irq_out=1 at 12, cause reads 16'h8002. Pulse irq_ack at 15 -> pending=0 at 16, irq_out=0 at 16. Drop irq_en at 17 -> SERVICE. Raise irq_en at 30 -> IDLE, irq_busy=0.
- Priority: mask=8'hFF, raise irq_src[5] and irq_src[1] in the same cycle -> cause.id=1. After the ack/disable/re-enable sequence, a second request with cause.id=5 follows within 2 cycles of irq_en returning.
- Masking and W1C: mask=0, edge on src 3 -> pending=8'h08 and irq_out stays 0. Write SR_BASE+1 with 16'h0008 -> pending=0. Write mask=8'h08 -> no request.
- Set/clear collision: in the same cycle as a W1C of bit 4, an edge on src 4 -> pending bit 4 stays 1. Same check with irq_ack clearing the cause bit while a new edge arrives on that source.
- Abort: in REQ, drop irq_en with no ack -> IDLE next cycle, irq_out=0, pending unchanged, cause.valid=0.
- Reset: assert rst=0 for 1 cycle during SERVICE -> mask, pending and cause all 0, state IDLE. Level-high sources do not re-trigger without a new rising edge. sr_out=0 for sr_sel=16'h0003.
